bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised, fully synchronous multi-digit BCD up/down counter with built-in prescaler, synchronous parallel load, wrap carry/borrow and per-digit seven-segment decode. It replaces ripple-clocked flip-flop decade counters in the lab designs: every register runs on the board clock and counts on a prescaler enable. It sits between the board clock/switches and the seven-segment driver.

## Interface
Parameters:
- `DIGITS`, 2, number of BCD digits (1–8).
- `DIV_N`, 12000000, board-clock cycles per count step (≥1).
- `DIV_WIDTH`, 32, prescaler counter width; must hold `DIV_N-1`.

Ports:
- `clk`  in  1  board clock; all state changes on rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `en`  in  1  count enable; gates the prescaler.
- `up_dn`  in  1  1 = count up, 0 = count down; sampled at each step.
- `load`  in  1  synchronous parallel load strobe.
- `load_val`  in  4*DIGITS  load value; digit i in bits [4i+3:4i].
- `bcd`  out  4*DIGITS  registered counter value, digit 0 least significant.
- `seg_led`  out  9*DIGITS  digit i pattern in [9i+8:9i]; bits 6:0 = segments g..a, active-high; bits 8:7 always 0.
- `tick`  out  1  one-cycle pulse after each count step.
- `carry`  out  1  one-cycle pulse after a wrap (up 99..9→00..0 or down 00..0→99..9).

## Operation
- Reset (`rst_n`=0, async): `bcd`=0, prescaler=0, `tick`=0, `carry`=0; `seg_led` shows 0 on every digit (subject to blanking, see Configuration).
- Prescaler `pre` counts 0..DIV_N-1 while `en`=1, holds its value while `en`=0. Internal `step` = `en` && `pre`==DIV_N-1; on `step`, `pre`→0.
- Priority per edge: `load` > `step` > hold.
- `load`=1: `bcd` ← `load_val` with any digit >9 clamped to 9; `pre`→0; `tick`=0, `carry`=0 next cycle. A `step` coincident with `load` is discarded.
- `step`, up: digit 0 increments; a digit at 9 becomes 0 and increments the next digit, all in the same edge. All digits 9 → all 0, `carry` set.
- `step`, down: digit 0 decrements; a digit at 0 becomes 9 and borrows from the next. All digits 0 → all 9, `carry` set.
- `tick` set on every `step` edge; both `tick` and `carry` clear on the following edge.
- `seg_led` decode (combinational from `bcd`): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F; unreachable codes →000.

## Timing
- Count latency: `bcd` changes on the edge where `step` is true; `tick`/`carry` are high for the cycle after that edge, aligned with the new value.
- Step period: exactly `DIV_N` cycles of continuous `en`; `DIV_N`=1 steps every enabled cycle.
- `en` dropping mid-period freezes `pre`; re-enabling resumes the remaining count.
- `up_dn` change takes effect at the next step, no extra latency.
- `load` → `bcd` valid one edge later; next step exactly `DIV_N` enabled cycles after the load edge.
- `seg_led` zero-cycle latency from `bcd`.
- Reset asserted mid-operation clears all state immediately; first step after release occurs `DIV_N` enabled cycles later.

## Configuration
- `BCD_LZ_BLANK_EN` defined: leading-zero blanking; digit i (i≥1) outputs 9'h000 when it and all higher digits are 0. Digit 0 is never blanked (reset shows single "0").
- Not defined: every digit always decoded; reset shows all digits "0".
- Counting, `tick` and `carry` behaviour identical in both builds.

## Test plan
(DIGITS=2, DIV_N=4 unless noted)
- Reset, `en`=1, `up_dn`=1, 40 cycles → `bcd` 00→01→…→0A not reached; after 10 steps `bcd`=8'h10, `tick` every 4th cycle, `carry` never.
- Load 8'h98, up, 2 steps → 99 then 00, `carry` high exactly one cycle after the 99→00 edge.
- Load 8'h00, `up_dn`=0, 1 step → `bcd`=8'h99, `carry` pulse; next step 98, no carry.
- Load 8'hFA (invalid) → `bcd`=8'h99; `load` on a step edge → load wins, next step 4 cycles later.
- `en` low after 2 enabled cycles for 10 cycles, then high → step after 2 more cycles; `rst_n` pulsed low mid-count → `bcd`=0, `tick`=0 asynchronously.
- With `BCD_LZ_BLANK_EN`: `bcd`=8'h05 → `seg_led`=18'h0006D; `bcd`=8'h10 → {06,3F}; without macro 8'h05 → {3F,6D}.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: prescaled multi-digit BCD up/down counter with load, wrap carry and 7-seg decode.
// Define BCD_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
module bcd_updown_counter #(
   parameter int DIGITS    = 2,
   parameter int DIV_N     = 12000000,
   parameter int DIV_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [9*DIGITS-1:0]   seg_led,
   output logic                  tick,
   output logic                  carry
);
`ifdef BCD_LZ_BLANK_EN
   localparam bit LZ_BLANK = 1'b1;
`else
   localparam bit LZ_BLANK = 1'b0;
`endif
   logic [DIV_WIDTH-1:0] pre_q, pre_d;
   logic [4*DIGITS-1:0]  bcd_q, bcd_d;
   logic                 tick_q, tick_d, carry_q, carry_d;
   logic                 step, chain, zero_above;
   logic [3:0]           dig, lv, nxt;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   assign step = en && (pre_q == DIV_WIDTH'(DIV_N - 1));

   always_comb begin
      bcd_d = bcd_q;
      chain = 1'b1;
      dig   = '0;
      lv    = '0;
      nxt   = '0;
      // chain stays high while every lower digit rolls over; at the top it flags a full wrap
      for (int i = 0; i < DIGITS; i++) begin
         dig = bcd_q[4*i+:4];
         lv  = load_val[4*i+:4];
         nxt = up_dn ? (dig == 4'd9 ? 4'd0 : dig + 4'd1) : (dig == 4'd0 ? 4'd9 : dig - 4'd1);
         if (load) bcd_d[4*i+:4] = lv > 4'd9 ? 4'd9 : lv;
         else if (step && chain) bcd_d[4*i+:4] = nxt;
         chain = chain & (up_dn ? dig == 4'd9 : dig == 4'd0);
      end
      pre_d   = (load || step) ? '0 : en ? pre_q + 1'b1 : pre_q;
      tick_d  = step && !load;
      carry_d = step && !load && chain;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q   <= '0;
         bcd_q   <= '0;
         tick_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         bcd_q   <= bcd_d;
         tick_q  <= tick_d;
         carry_q <= carry_d;
      end
   end

   always_comb begin
      seg_led    = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above & (bcd_q[4*i+:4] == 4'd0);
         seg_led[9*i+:9] = (LZ_BLANK && zero_above && i != 0) ? 9'h000 : {2'b00, seg7(bcd_q[4*i+:4])};
      end
   end

   assign bcd   = bcd_q;
   assign tick  = tick_q;
   assign carry = carry_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: scoreboard bench; an integer-valued reference model queues expected outputs per edge.
module tb_bcd_updown_counter;
   localparam int DIGITS = 2;
   localparam int DIV_N  = 4;
   localparam int MAXV   = 100;

   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, up_dn = 1'b1, load = 1'b0;
   logic [4*DIGITS-1:0] load_val = '0, bcd;
   logic [9*DIGITS-1:0] seg_led;
   logic tick, carry;

   typedef struct {
      logic [4*DIGITS-1:0] bcd;
      logic [9*DIGITS-1:0] seg;
      logic                tick;
      logic                carry;
   } exp_t;

   exp_t q[$];
   int checks = 0, errors = 0;
   int val = 0, pre = 0;
   bit m_tick = 0, m_carry = 0;
   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   bcd_updown_counter #(.DIGITS(DIGITS), .DIV_N(DIV_N), .DIV_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .bcd(bcd), .seg_led(seg_led), .tick(tick), .carry(carry)
   );

   always #5 clk = ~clk;

   function automatic exp_t expect_now();
      exp_t e;
      bit blank;
      for (int i = 0; i < DIGITS; i++) begin
         int d = (val / (10 ** i)) % 10;
         e.bcd[4*i+:4] = 4'(d);
`ifdef BCD_LZ_BLANK_EN
         blank = i > 0 && val < 10 ** i;
`else
         blank = 0;
`endif
         e.seg[9*i+:9] = blank ? 9'h000 : {2'b00, seg_tab[d]};
      end
      e.tick  = m_tick;
      e.carry = m_carry;
      return e;
   endfunction

   function automatic int clamp(input logic [4*DIGITS-1:0] lv);
      int r = 0;
      for (int i = 0; i < DIGITS; i++) begin
         int d = int'(lv[4*i+:4]);
         r += (d > 9 ? 9 : d) * (10 ** i);
      end
      return r;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input exp_t e, input string tag);
      cmp({tag, ".bcd"}, 32'(bcd), 32'(e.bcd));
      cmp({tag, ".seg"}, 32'(seg_led), 32'(e.seg));
      cmp({tag, ".tick"}, 32'(tick), 32'(e.tick));
      cmp({tag, ".carry"}, 32'(carry), 32'(e.carry));
   endtask

   task automatic model_reset();
      val = 0; pre = 0; m_tick = 0; m_carry = 0;
   endtask

   task automatic model_edge();
      bit step = en && pre == DIV_N - 1;
      if (load) begin
         val = clamp(load_val); pre = 0; m_tick = 0; m_carry = 0;
      end else if (step) begin
         pre = 0; m_tick = 1;
         m_carry = up_dn ? val == MAXV - 1 : val == 0;
         val = up_dn ? (val + 1) % MAXV : (val + MAXV - 1) % MAXV;
      end else begin
         m_tick = 0; m_carry = 0;
         if (en) pre++;
      end
   endtask

   task automatic cyc(input bit e, input bit u, input bit l, input logic [4*DIGITS-1:0] lv);
      en = e; up_dn = u; load = l; load_val = lv;
      @(posedge clk);
      model_edge();
      q.push_back(expect_now());
      #1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check_all(e, "edge");
         end
      end
   end

   initial begin
      #12;
      check_all(expect_now(), "reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (40) cyc(1, 1, 0, '0);
      cmp("ten_steps", 32'(bcd), 32'h10);
      cyc(1, 1, 1, 8'h98);
      repeat (8) cyc(1, 1, 0, '0);
      cyc(1, 0, 1, 8'h00);
      repeat (8) cyc(1, 0, 0, '0);
      cyc(1, 1, 1, 8'hFA);
      cmp("clamp", 32'(bcd), 32'h99);
      repeat (3) cyc(1, 1, 0, '0);
      cyc(1, 1, 1, 8'h42);
      repeat (5) cyc(1, 1, 0, '0);
      repeat (2) cyc(1, 1, 0, '0);
      repeat (10) cyc(0, 1, 0, '0);
      repeat (3) cyc(1, 1, 0, '0);
      repeat (6) cyc(1, 1, 0, '0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      model_reset();
      #1 check_all(expect_now(), "async_rst");
      @(posedge clk);
      q.push_back(expect_now());
      #1 rst_n = 1'b1;
      repeat (3000) cyc($urandom_range(0, 9) != 0, 1'($urandom), $urandom_range(0, 29) == 0, 8'($urandom));
      @(negedge clk);
      @(negedge clk);
      #1 cmp("queue_drain", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
